// File: rtl/servo_pkg.sv
// ============================================================================
// Module      : servo_pkg
// Description : Shared types and defaults for the servo drive and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package servo_pkg;

    localparam int PW_W         = 32;
    localparam int STEP_W       = 16;
    localparam int FRAME_CYCLES = 10;
    localparam int PW_RESET     = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_e;

    function automatic logic [PW_W-1:0] clamp_pw(
        input logic [PW_W-1:0] value,
        input logic [PW_W-1:0] lo,
        input logic [PW_W-1:0] hi
    );
        if (value < lo)      return lo;
        else if (value > hi) return hi;
        else                 return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/servo_frame_timer.sv
// ============================================================================
// Module      : servo_frame_timer
// Description : PWM frame counter with a registered tick on the last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_frame_timer #(
    parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);
    import servo_pkg::*;

    localparam int                c_cnt_w = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(FRAME_CYCLES - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;
    logic               tick_q;
    logic               tick_d;

    // Tick is derived from the next count so it is high exactly while count == last.
    always_comb begin
        cnt_d  = (cnt_q == c_last) ? '0 : cnt_q + c_cnt_w'(1);
        tick_d = (cnt_d == c_last);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/servo_pos_sequencer.sv
// ============================================================================
// Module      : servo_pos_sequencer
// Description : Clamps pulse-width commands and slews the applied width toward
//               the target once per PWM frame. Optional SERVO_HOLD_RELEASE_EN
//               drops the output to 0 after HOLD_FRAMES idle frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_pos_sequencer #(
    parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES,
    parameter int PW_MIN       = 1,
    parameter int PW_MAX       = 9,
    parameter int PW_RESET     = servo_pkg::PW_RESET
`ifdef SERVO_HOLD_RELEASE_EN
    ,
    parameter int HOLD_FRAMES  = 50
`endif
) (
    input  logic                          clock_clk,
    input  logic                          reset_low,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [servo_pkg::PW_W-1:0]    cmd_target,
    input  logic [servo_pkg::STEP_W-1:0]  cmd_step,
    input  logic                          abort,
    output logic [servo_pkg::PW_W-1:0]    pulse_time,
    output logic                          frame_tick,
    output logic                          busy,
    output logic                          done,
    output logic                          clamp_err
);
    import servo_pkg::*;

    localparam logic [PW_W-1:0] c_pw_min   = PW_W'(PW_MIN);
    localparam logic [PW_W-1:0] c_pw_max   = PW_W'(PW_MAX);
    localparam logic [PW_W-1:0] c_pw_reset = PW_W'(PW_RESET);

    state_e              state_q, state_d;
    logic [PW_W-1:0]     pw_q, pw_d;
    logic [PW_W-1:0]     tgt_q, tgt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                done_q, done_d;
    logic                clamp_q, clamp_d;

    logic                w_hs;
    logic [PW_W-1:0]     w_clamped;
    logic [PW_W-1:0]     w_step_ext;
    logic                w_up;
    logic [PW_W-1:0]     w_diff;
    logic                w_final;
    logic                w_released;

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_timer (
        .clk_i   (clock_clk),
        .rst_n_i (reset_low),
        .tick_o  (frame_tick)
    );

`ifdef SERVO_HOLD_RELEASE_EN
    localparam int                 c_idle_w    = $clog2(HOLD_FRAMES + 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(HOLD_FRAMES - 1);

    logic [c_idle_w-1:0] idle_q, idle_d;
    logic                rel_q, rel_d;

    assign w_released = rel_q;
`else
    assign w_released = 1'b0;
`endif

    assign w_hs       = cmd_valid && (state_q == ST_IDLE);
    assign w_clamped  = clamp_pw(cmd_target, c_pw_min, c_pw_max);
    assign w_step_ext = {{(PW_W-STEP_W){1'b0}}, step_q};
    // Direction is decided first so the magnitude never underflows.
    assign w_up       = (tgt_q >= pw_q);
    assign w_diff     = w_up ? (tgt_q - pw_q) : (pw_q - tgt_q);
    assign w_final    = (step_q == '0) || (w_diff <= w_step_ext) || w_released;

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        done_d  = 1'b0;
        clamp_d = 1'b0;
`ifdef SERVO_HOLD_RELEASE_EN
        idle_d  = idle_q;
        rel_d   = rel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_hs) begin
                    tgt_d   = w_clamped;
                    step_d  = cmd_step;
                    clamp_d = (w_clamped != cmd_target);
                    state_d = ST_RAMP;
`ifdef SERVO_HOLD_RELEASE_EN
                    idle_d  = '0;
                end else if (frame_tick && !rel_q) begin
                    if (idle_q == c_idle_last) begin
                        pw_d   = '0;
                        rel_d  = 1'b1;
                        idle_d = '0;
                    end else begin
                        idle_d = idle_q + c_idle_w'(1);
                    end
`endif
                end
            end
            ST_RAMP: begin
`ifdef SERVO_HOLD_RELEASE_EN
                idle_d = '0;
`endif
                // A completing update takes priority over a coincident abort.
                if (frame_tick && w_final) begin
                    pw_d    = tgt_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef SERVO_HOLD_RELEASE_EN
                    rel_d   = 1'b0;
`endif
                end else if (abort) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    pw_d = w_up ? (pw_q + w_step_ext) : (pw_q - w_step_ext);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_clk) begin
        if (!reset_low) begin
            state_q <= ST_IDLE;
            pw_q    <= c_pw_reset;
            tgt_q   <= c_pw_reset;
            step_q  <= '0;
            done_q  <= 1'b0;
            clamp_q <= 1'b0;
`ifdef SERVO_HOLD_RELEASE_EN
            idle_q  <= '0;
            rel_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            done_q  <= done_d;
            clamp_q <= clamp_d;
`ifdef SERVO_HOLD_RELEASE_EN
            idle_q  <= idle_d;
            rel_q   <= rel_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RAMP);
    assign pulse_time = pw_q;
    assign done       = done_q;
    assign clamp_err  = clamp_q;

endmodule

`default_nettype wire

// File: doc/servo_pos_sequencer.md
Name: servo_pos_sequencer

Overview:
Position-command controller that sequences the pulseTime input of the servo PWM drive. It accepts target pulse-width commands over a valid/ready handshake and clamps them to a safe range. It slews the applied pulse width toward the target by a per-command step, updating only at PWM frame boundaries so a frame is never glitched. It sits between the forklift motion FSM and the servo drive, and runs a frame counter aligned with the drive's period counter.

Parameters:
FRAME_CYCLES, 10, PWM frame length in clocks; must equal the drive's period.
PW_MIN, 1, minimum legal pulse width (clocks).
PW_MAX, 9, maximum legal pulse width (clocks).
PW_RESET, 5, neutral pulse width applied after reset.
HOLD_FRAMES, 50, idle frames before release (optional feature only).

Ports:
clock_clk  in  1  system clock
reset_low  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out 1  command can be accepted
cmd_target in  32 requested pulse width, unsigned
cmd_step   in  16 max change per frame; 0 = jump in one frame
abort      in  1  stop ramp, hold current width
pulse_time out 32 to servo drive pulseTime
frame_tick out 1  1-cycle pulse on last cycle of each frame
busy       out 1  ramp in progress
done       out 1  1-cycle pulse when target reached
clamp_err  out 1  1-cycle pulse when accepted target was clamped

Behaviour:
- Reset: the only clock is clock_clk. reset_low is synchronous and active-low: it is sampled on rising clock_clk only.
  Reset values: pulse_time=PW_RESET, frame count=0, frame_tick=0, state IDLE, cmd_ready=1, busy=0, done=0, clamp_err=0.
- Reset mid-ramp: it takes effect on the next edge. The ramp is discarded and the frame counter restarts at 0, aligned with the drive, which resets on the same signal.
- Frame counter: counts 0..FRAME_CYCLES-1 and wraps. frame_tick=1 (registered) while the count equals FRAME_CYCLES-1.
- States: IDLE, RAMP.
- IDLE:
  - cmd_ready=1, busy=0.
  - A handshake (cmd_valid&cmd_ready at an edge) latches:
    - target = clamp(cmd_target, PW_MIN, PW_MAX);
    - step = cmd_step.
  - On that handshake: go to RAMP. Next cycle cmd_ready=0 and busy=1. clamp_err pulses next cycle if clamping changed the value.
  - A target equal to the current pulse_time still enters RAMP and completes at the next tick, with done.
  - abort is ignored in IDLE. If abort and cmd_valid arrive in the same cycle in IDLE, the command is accepted.
- RAMP:
  - Updates happen only on cycles where frame_tick=1.
  - Let diff = |target - pulse_time|. Compare before subtracting; no unsigned underflow.
  - If step==0 or diff<=step: pulse_time<=target, done pulses on the same edge, and the state returns to IDLE (cmd_ready=1 next cycle).
  - Otherwise pulse_time moves toward target by step.
- Latency: the first pulse_time change becomes visible on the edge of the first frame_tick that is strictly after the accept cycle. A handshake in the same cycle as frame_tick waits for the next frame.
- abort in RAMP: IDLE on the next edge. pulse_time holds, done is not pulsed. abort on the same cycle as the final update: the final update wins and done pulses.
- Arithmetic: pulse_time is always within [PW_MIN, PW_MAX] except PW_RESET at reset (and 0 when released, see optional feature). step is zero-extended to 32 bits.

Optional Feature:
SERVO_HOLD_RELEASE_EN
- Defined:
  - IDLE counts frame_ticks since entry. After HOLD_FRAMES ticks with no handshake, pulse_time<=0 at that tick, which gives constant-low PWM so the servo is unpowered.
  - The next accepted command from the released state ignores step and applies target at the first tick. done pulses as normal.
  - Reset or a handshake clears the count.
- Undefined: IDLE holds pulse_time indefinitely. No counter logic is present.

Decomposition:
- Package servo_pkg contains:
  - the state enum (IDLE, RAMP);
  - PW_W=32 and STEP_W=16;
  - shared defaults FRAME_CYCLES=10 and PW_RESET=5, so the drive and sequencer agree.
- Sub-module servo_frame_timer: the frame counter plus frame_tick generation. It is reusable by the drive.

Test Plan:
1. Hold reset_low=0 for 3 cycles, then release -> pulse_time=5, cmd_ready=1, busy=0. First frame_tick on cycle 9 after release.
2. From 5, cmd target=8 step=1 -> pulse_time 6, 7, 8 on three consecutive ticks, 10 cycles apart. done is a single pulse with 8; busy clears.
3. From 8, target=3 step=2 -> 6, 4, 3 (final partial step). Then target=3 again -> no change, done at the next tick.
4. target=20 step=0 -> clamp_err pulse, pulse_time=9 at the next tick. target=0 -> clamp_err, pulse_time=1.
5. From 9, target=1 step=1; assert abort after the second tick -> pulse_time stays 7, no done, cmd_ready=1 next cycle.
6. Pulse reset_low low for 1 cycle mid-ramp -> pulse_time=5, busy=0, and frame count 0 on the next edge. With SERVO_HOLD_RELEASE_EN, HOLD_FRAMES=2: after 2 idle ticks pulse_time=0.
